pwm_audio_out: RTL and testbench
================================

Name: pwm_audio_out

Overview:
- Output stage directly downstream of the waveform generator top.
- Consumes the 8-bit waveform and its enable flag, and drives the board's mono PWM audio pins (AUD_PWM, AUD_SD).
- Converts each sample to a pulse-width-modulated level with a per-period sample latch.
- Sequences amplifier power (wake delay, midscale settle, drain) so enable toggles do not produce clicks.

Parameters:
- CLK_DIV, 4: clk cycles per PWM count tick; legal range 1..255. PWM period = CLK_DIV*256 clk.
- WAKE_CYCLES, 100000: clk cycles spent in WAKE, at midscale, before RUN (1 ms at 100 MHz); must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- sampleIn  in  8  unsigned waveform sample
- enableIn  in  1  waveform enabled flag
- audPwm  out  1  PWM level; 1 = release pin (top-level maps to high-Z), 0 = drive low
- audSd  out  1  amplifier shutdown_n; 1 = amplifier on
- running  out  1  high while state == RUN
- sampleTaken  out  1  one-clk pulse when a new duty value is latched

Behaviour:
- Reset (async assert, sync release) values:
  - state = OFF
  - divCnt, pwmCnt, duty, audPwm, audSd, running, sampleTaken = 0
  - drainPhase = 0
- Prescaler:
  - divCnt counts 0..CLK_DIV-1.
  - tick = (divCnt == CLK_DIV-1).
  - divCnt and pwmCnt are held at 0 in OFF.
- PWM counter:
  - pwmCnt (8 bit) increments on tick and wraps 255 -> 0.
  - Period boundary = tick && pwmCnt == 255.
- Duty latch, on a period boundary only:
  - duty <= RUN ? sampleIn : MIDSCALE (0x80).
  - sampleTaken = 1 for exactly that clk, and only when the boundary occurs in RUN.
  - sampleIn is ignored at all other cycles.
- Output:
  - audPwm <= (state != OFF) && (pwmCnt < duty), registered, so 1 clk latency from counter/duty.
  - duty 0x00 gives audPwm constantly 0.
  - duty 0xFF gives 255 high ticks out of 256.
- FSM:
  - OFF: audSd=0. If enableIn=1, go to WAKE, load wakeCnt = WAKE_CYCLES-1, set duty = 0x80.
  - WAKE: audSd=1, duty forced 0x80. wakeCnt decrements each clk. When wakeCnt == 0, go to RUN.
  - WAKE abort: enableIn=0 during WAKE goes directly to OFF next clk. This abort has priority over wake expiry.
  - RUN: audSd=1, running=1. If enableIn=0, go to DRAIN with drainPhase = 0.
  - DRAIN: audSd=1.
    - At the first period boundary: duty <= 0x80, drainPhase = 1.
    - At the next period boundary: go to OFF.
    - enableIn is ignored in DRAIN; re-enable is honoured only from OFF.
- Entering OFF: duty <= 0, and the counters are cleared on the same clk.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronous). audSd drops with no drain sequence.
- Simultaneous events:
  - Period boundary on the same clk as RUN -> DRAIN: the latch takes the RUN branch (sampleIn), and the transition still happens.
  - enableIn toggling within one clk: the FSM acts on the registered edge value only; enableIn is not synchronised internally (it is on-chip).

Decomposition:
- Shared package pwm_audio_pkg holds:
  - state encoding localparams: OFF=2'd0, WAKE=2'd1, RUN=2'd2, DRAIN=2'd3
  - MIDSCALE = 8'h80
  - PWM_BITS = 8
- One sub-module, pwm_core:
  - contains the prescaler, pwmCnt, duty register, comparator and boundary strobe
  - inputs: hold, nextDuty
  - output: boundary
- The FSM stays in pwm_audio_out.

Test Plan:
- Run all scenarios with CLK_DIV=1 and WAKE_CYCLES=16.
- Power-up: release reset with enableIn=0 for 1000 clk -> audSd=0, audPwm=0, sampleTaken never pulses.
- Wake then run: enableIn=1, sampleIn=0x40 -> audSd=1 next clk. During WAKE, audPwm is high 128 of every 256 clk. running=1 after 16 clk. After the first boundary in RUN, exactly 64 high clk per 256-clk period, and sampleTaken pulses once per period.
- Duty extremes: in RUN, sampleIn=0x00 -> audPwm 0 for a whole period. sampleIn=0xFF -> 255 high, 1 low per period. Change sampleIn mid-period -> the current period is unchanged.
- Drain: drop enableIn mid-period with sample 0xC0 -> the current period completes at 192 high. Then one period at 128 high, then OFF with audSd=0 and audPwm=0. Re-asserting enableIn during DRAIN has no effect until OFF.
- Wake abort: enableIn=1 for 5 clk then 0 -> OFF after 6 clk, running never set.
- Async reset: assert reset mid-RUN between clock edges -> audSd, audPwm and running go to 0 immediately, with no dependence on the clock.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// Shared types and constants for the PWM audio output stage.
package pwm_audio_pkg;

  localparam int unsigned PWM_BITS = 8;
  localparam logic [PWM_BITS-1:0] MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_core.sv
// Prescaled 8-bit PWM counter, per-period duty latch and registered comparator.
module pwm_core
  import pwm_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold,
  input  logic                active,
  input  logic                load,
  input  logic [PWM_BITS-1:0] nextDuty,
  output logic                boundary,
  output logic                audPwm
);

  localparam logic [7:0]          DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

  logic [7:0]          r_divCnt;
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_audPwm;
  logic                w_tick;

  assign w_tick   = (r_divCnt == DIV_LAST);
  // Not gated by hold: hold depends on the FSM's next state, which depends on boundary.
  assign boundary = w_tick && (r_pwmCnt == CNT_LAST);
  assign audPwm   = r_audPwm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_divCnt <= '0;
      r_pwmCnt <= '0;
    end else if (hold) begin
      r_divCnt <= '0;
      r_pwmCnt <= '0;
    end else begin
      r_divCnt <= w_tick ? '0 : r_divCnt + 8'd1;
      if (w_tick) begin
        r_pwmCnt <= r_pwmCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_duty <= '0;
    end else if (load || boundary) begin
      r_duty <= nextDuty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_audPwm <= 1'b0;
    end else begin
      r_audPwm <= active && (r_pwmCnt < r_duty);
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// Mono PWM audio output with click-free amplifier power sequencing.
module pwm_audio_out
  import pwm_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned WAKE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sampleIn,
  input  logic       enableIn,
  output logic       audPwm,
  output logic       audSd,
  output logic       running,
  output logic       sampleTaken
);

  localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [WAKE_W-1:0]   r_wakeCnt;
  logic [WAKE_W-1:0]   w_nextWakeCnt;
  logic                r_drainPhase;
  logic                w_nextDrainPhase;
  logic                r_sampleTaken;
  logic                w_boundary;
  logic                w_enterOff;
  logic                w_hold;
  logic                w_load;
  logic [PWM_BITS-1:0] w_nextDuty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= OFF;
      r_wakeCnt     <= '0;
      r_drainPhase  <= 1'b0;
      r_sampleTaken <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_wakeCnt     <= w_nextWakeCnt;
      r_drainPhase  <= w_nextDrainPhase;
      r_sampleTaken <= w_boundary && (r_state == RUN);
    end
  end

  always_comb begin
    w_nextState      = r_state;
    w_nextWakeCnt    = r_wakeCnt;
    w_nextDrainPhase = r_drainPhase;
    unique case (r_state)
      OFF: begin
        if (enableIn) begin
          w_nextState      = WAKE;
          w_nextWakeCnt    = WAKE_LOAD;
          w_nextDrainPhase = 1'b0;
        end
      end
      WAKE: begin
        if (!enableIn) begin
          w_nextState = OFF;
        end else if (r_wakeCnt == '0) begin
          w_nextState = RUN;
        end else begin
          w_nextWakeCnt = r_wakeCnt - 1'b1;
        end
      end
      RUN: begin
        if (!enableIn) begin
          w_nextState      = DRAIN;
          w_nextDrainPhase = 1'b0;
        end
      end
      DRAIN: begin
        if (w_boundary) begin
          if (r_drainPhase) begin
            w_nextState      = OFF;
            w_nextDrainPhase = 1'b0;
          end else begin
            w_nextDrainPhase = 1'b1;
          end
        end
      end
      default: w_nextState = OFF;
    endcase
  end

  // Duty source: zero on entering OFF, live sample only for boundaries seen in RUN.
  always_comb begin
    w_enterOff = (r_state != OFF) && (w_nextState == OFF);
    w_hold     = (r_state == OFF) || w_enterOff;
    w_load     = w_enterOff || ((r_state == OFF) && (w_nextState == WAKE));
    if (w_enterOff) begin
      w_nextDuty = '0;
    end else if (r_state == RUN) begin
      w_nextDuty = sampleIn;
    end else begin
      w_nextDuty = MIDSCALE;
    end
  end

  pwm_core #(
    .CLK_DIV(CLK_DIV)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .hold     (w_hold),
    .active   (r_state != OFF),
    .load     (w_load),
    .nextDuty (w_nextDuty),
    .boundary (w_boundary),
    .audPwm   (audPwm)
  );

  assign audSd       = (r_state != OFF);
  assign running     = (r_state == RUN);
  assign sampleTaken = r_sampleTaken;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed/randomized bench for pwm_audio_out with CLK_DIV=1, WAKE_CYCLES=16.
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sampleIn = 8'h00;
  logic       enableIn = 1'b0;
  logic       audPwm;
  logic       audSd;
  logic       running;
  logic       sampleTaken;

  int checks = 0;
  int failures = 0;

  pwm_audio_out #(
    .CLK_DIV     (1),
    .WAKE_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sampleIn    (sampleIn),
    .enableIn    (enableIn),
    .audPwm      (audPwm),
    .audSd       (audSd),
    .running     (running),
    .sampleTaken (sampleTaken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 256-clk PWM period starting just after a boundary edge. The model:
  // high clocks in a period equal the duty latched at the preceding boundary,
  // and sampleTaken pulses once iff that period's closing boundary is in RUN.
  task automatic run_window(input string tag, input int exp_hi, input int exp_st,
                            input int exp_run, input int exp_sd, input logic [7:0] next_s,
                            input int drop_at, input int rea_at);
    int hi;
    int st;
    int rn;
    int sd;
    int c1;
    int c2;
    hi = 0; st = 0; rn = 0; sd = 0;
    c1 = int'($urandom_range(1, 120));
    c2 = int'($urandom_range(121, 250));
    for (int j = 1; j <= 256; j++) begin
      tick();
      hi += int'(audPwm);
      st += int'(sampleTaken);
      rn += int'(running);
      sd += int'(audSd);
      if (j == c1) sampleIn = 8'($urandom);
      if (j == c2) sampleIn = next_s;
      if (j == drop_at) enableIn = 1'b0;
      if (j == rea_at) enableIn = 1'b1;
    end
    chk({tag, ".high"}, hi, exp_hi);
    chk({tag, ".taken"}, st, exp_st);
    chk({tag, ".running"}, rn, exp_run);
    chk({tag, ".audSd"}, sd, exp_sd);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    int         drop;
    int         cnt_sd;
    int         cnt_pwm;
    int         cnt_st;
    int         cnt_run;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.audSd", audSd, 0);
    chk("rst.audPwm", audPwm, 0);
    chk("rst.running", running, 0);
    chk("rst.sampleTaken", sampleTaken, 0);
    reset = 1'b1;

    // Idle power-up
    cnt_sd = 0; cnt_pwm = 0; cnt_st = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      cnt_sd  += int'(audSd);
      cnt_pwm += int'(audPwm);
      cnt_st  += int'(sampleTaken);
    end
    chk("idle.audSd", cnt_sd, 0);
    chk("idle.audPwm", cnt_pwm, 0);
    chk("idle.taken", cnt_st, 0);

    // Wake then run: wake period at midscale, RUN from the 16th edge on
    sampleIn = 8'h40;
    enableIn = 1'b1;
    tick();
    chk("wake.audSd", audSd, 1);
    chk("wake.running", running, 0);
    run_window("wake", 128, 1, 241, 256, 8'h40, 0, 0);
    run_window("run40", 64, 1, 256, 256, 8'h00, 0, 0);
    run_window("run00", 0, 1, 256, 256, 8'hFF, 0, 0);
    cur = 8'($urandom);
    run_window("runFF", 255, 1, 256, 256, cur, 0, 0);
    for (int k = 0; k < 4; k++) begin
      nxt = (k == 3) ? 8'hC0 : 8'($urandom);
      run_window($sformatf("rand%0d_%0d", k, cur), int'(cur), 1, 256, 256, nxt, 0, 0);
      cur = nxt;
    end

    // Drain: drop enable mid-period, then re-assert it during DRAIN
    drop = int'($urandom_range(40, 200));
    run_window("drain0", 192, 0, drop, 256, 8'h11, drop, 0);
    run_window("drain1", 128, 0, 0, 255, 8'h22, 0, int'($urandom_range(10, 200)));
    chk("off.audSd", audSd, 0);
    chk("off.audPwm", audPwm, 0);
    chk("off.running", running, 0);
    enableIn = 1'b0;
    cnt_sd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt_sd += int'(audSd);
    end
    chk("off.stays", cnt_sd, 0);

    // Wake abort
    cnt_run = 0;
    enableIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt_run += int'(running);
    end
    chk("abort.awake", audSd, 1);
    enableIn = 1'b0;
    tick();
    cnt_run += int'(running);
    chk("abort.audSd", audSd, 0);
    tick();
    cnt_run += int'(running);
    chk("abort.audPwm", audPwm, 0);
    cnt_sd = 0; cnt_pwm = 0; cnt_st = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cnt_sd  += int'(audSd);
      cnt_pwm += int'(audPwm);
      cnt_st  += int'(sampleTaken);
      cnt_run += int'(running);
    end
    chk("abort.running", cnt_run, 0);
    chk("abort.idleSd", cnt_sd, 0);
    chk("abort.idlePwm", cnt_pwm, 0);
    chk("abort.idleTaken", cnt_st, 0);

    // Async reset mid-RUN, between clock edges
    sampleIn = 8'hFF;
    enableIn = 1'b1;
    repeat (300) tick();
    chk("pre.running", running, 1);
    chk("pre.audSd", audSd, 1);
    chk("pre.audPwm", audPwm, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.audSd", audSd, 0);
    chk("arst.audPwm", audPwm, 0);
    chk("arst.running", running, 0);
    chk("arst.taken", sampleTaken, 0);
    repeat (2) tick();
    chk("arst.hold", audSd, 0);
    reset = 1'b1;
    enableIn = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
